// File: rtl/booth_radix4_multiplier.sv
// rtl/booth_radix4_multiplier.sv - sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; discards any operation in flight
//   start     request; accepted whenever busy is low (IDLE or DONE)
//   a         multiplicand, sampled on an accepted start
//   b         multiplier, sampled on an accepted start
//   is_signed 1 = both operands two's complement, 0 = both unsigned
//   busy      high while recoding steps run
//   done      one-cycle pulse, product valid
//   product   2*WIDTH result, held until the next operation completes
module booth_radix4_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int PW   = 2 * WIDTH + 4;  // accumulator / shifted multiplicand width
    localparam int BW   = WIDTH + 3;      // extended multiplier plus the implicit b[-1]
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   m_reg;   // multiplicand, pre-shifted by 4^k for step k
    logic [BW-1:0]   b_reg;   // multiplier; low three bits are the current triplet
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_next;
    logic            accept;
    logic            last_step;

    assign accept    = start && (state != RUN);
    assign last_step = (cnt == CW'(ITER - 1));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Booth digit selection; 2M is the stored multiplicand shifted by one,
    // negation is two's complement at the full accumulator width.
    always_comb begin
        addend = '0;
        case (b_reg[2:0])
            3'b001, 3'b010: addend = m_reg;
            3'b011:         addend = {m_reg[PW-2:0], 1'b0};
            3'b100:         addend = -{m_reg[PW-2:0], 1'b0};
            3'b101, 3'b110: addend = -m_reg;
            default:        addend = '0;
        endcase
    end

    assign acc_next = acc + addend;

    // Shifted-add form: instead of shifting the accumulator right, the
    // multiplicand moves left by two each step, so acc directly holds the
    // partial product and its low 2*WIDTH bits are the final result.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m_reg <= {{(PW - WIDTH){is_signed & a[WIDTH-1]}}, a};
            b_reg <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            m_reg <= {m_reg[PW-3:0], 2'b00};
            b_reg <= {2'b00, b_reg[BW-1:2]};
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                product <= acc_next[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb/tb_booth_radix4_multiplier.sv - self-checking bench for booth_radix4_multiplier at WIDTH 8, 16 and 4
module tb_booth_radix4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s8, s16, s4;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic        sg8, sg16, sg4;
    logic        busy8, busy16, busy4;
    logic        done8, done16, done4;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [7:0]  p4;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8), .is_signed(sg8),
        .busy(busy8), .done(done8), .product(p8));
    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(s16), .a(a16), .b(b16), .is_signed(sg16),
        .busy(busy16), .done(done16), .product(p16));
    booth_radix4_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(s4), .a(a4), .b(b4), .is_signed(sg4),
        .busy(busy4), .done(done4), .product(p4));

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;
    int last_busy;

    always @(negedge clk) begin
        if ((busy8 && done8) || (busy16 && done16) || (busy4 && done4)) overlap++;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact mathematical product, reduced to 2*w bits.
    function automatic longint ref_prod(input int w, input longint av, input longint bv, input bit sg);
        longint x, y, m;
        m = (longint'(1) << w) - 1;
        x = av & m;
        y = bv & m;
        if (sg && x[w-1]) x = x - (longint'(1) << w);
        if (sg && y[w-1]) y = y - (longint'(1) << w);
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic bit get_done(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done4;
        endcase
    endfunction

    function automatic bit get_busy(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy4;
        endcase
    endfunction

    function automatic longint get_prod(input int w);
        case (w)
            8:       return longint'(p8);
            16:      return longint'(p16);
            default: return longint'(p4);
        endcase
    endfunction

    task automatic drive(input int w, input longint av, input longint bv, input bit sg, input bit st);
        case (w)
            8:       begin a8 = av[7:0];   b8 = bv[7:0];   sg8 = sg;  s8 = st;  end
            16:      begin a16 = av[15:0]; b16 = bv[15:0]; sg16 = sg; s16 = st; end
            default: begin a4 = av[3:0];   b4 = bv[3:0];   sg4 = sg;  s4 = st;  end
        endcase
    endtask

    // One operation: start for one edge, then count edges until done.
    task automatic run_op(input string tag, input int w, input longint av, input longint bv,
                          input bit sg, input int exp_lat);
        int lat;
        drive(w, av, bv, sg, 1'b1);
        @(posedge clk); #1;
        drive(w, av, bv, sg, 1'b0);
        lat = 1;
        last_busy = 0;
        while (!get_done(w) && lat < 60) begin
            if (get_busy(w)) last_busy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " product"}, get_prod(w), ref_prod(w, av, bv, sg));
    endtask

    typedef struct {
        longint av;
        longint bv;
        bit     sg;
        longint exp;
    } corner_t;

    corner_t corners[4] = '{
        '{-128, -128, 1'b1, 64'h4000},
        '{-128,  127, 1'b1, 64'hC080},
        '{ 255,  255, 1'b0, 64'hFE01},
        '{   0,  200, 1'b0, 64'h0000}
    };

    initial begin
        int     pulses;
        int     lat;
        longint pr;

        reset = 1'b1;
        drive(8, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset product", p8, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("neg7x5", 8, -7, 5, 1'b1, 6);
        check("neg7x5 const", p8, 64'hFFDD);
        check("neg7x5 busy cycles", last_busy, 5);

        // product holds after done
        repeat (3) @(posedge clk);
        #1;
        check("product hold", p8, 64'hFFDD);

        foreach (corners[i]) begin
            run_op("corner", 8, corners[i].av, corners[i].bv, corners[i].sg, 6);
            check("corner const", p8, corners[i].exp);
        end

        // start during RUN is ignored
        drive(8, 10, -3, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(8, 10, -3, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8, 99, 77, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 99, 77, 1'b0, 1'b0);
        pulses = 0;
        pr = 0;
        for (int i = 0; i < 14; i++) begin
            if (done8) begin
                pulses++;
                pr = longint'(p8);
            end
            @(posedge clk); #1;
        end
        check("ignored start pulses", pulses, 1);
        check("ignored start product", pr, 64'hFFE2);

        // reset in the middle of RUN
        drive(8, 20, 6, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 20, 6, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrun reset busy", busy8, 0);
        check("midrun reset done", done8, 0);
        check("midrun reset product", p8, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) pulses++;
            @(posedge clk); #1;
        end
        check("midrun reset no done", pulses, 0);
        run_op("after reset", 8, 20, 6, 1'b0, 6);

        // back-to-back with start held high
        drive(8, 3, 4, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(8, -2, -2, 1'b1, 1'b1);
        lat = 1;
        while (!done8 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b first latency", lat, 6);
        check("b2b first product", p8, 12);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done8 && lat < 60);
        drive(8, -2, -2, 1'b1, 1'b0);
        check("b2b spacing", lat, 6);
        check("b2b second product", p8, 4);
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            run_op("rand16", 16, longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)), 10);
        end
        for (int i = 0; i < 1000; i++) begin
            run_op("rand4", 4, longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)), 4);
        end

        check("busy/done overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_radix4_multiplier.md
# booth_radix4_multiplier

Parametrised sequential multiplier using radix-4 (modified) Booth recoding. It retires two multiplier bits per cycle. It serves both signed and unsigned operands, selected per operation, and uses a start/busy/done handshake. It sits in the datapath alongside the radix-2 Booth unit and replaces it where operand width or throughput must scale.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥ 4
- ITER, WIDTH/2+1, derived and not overridable; number of recoding steps

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled on the rising edge
- a  input  WIDTH  multiplicand; sampled with an accepted start
- b  input  WIDTH  multiplier; sampled with an accepted start
- is_signed  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with an accepted start
- busy  output  1  high while recoding steps are in progress
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; holds until the next accepted start completes

## Operation
- States: IDLE, RUN, DONE.
- Start is accepted when state is IDLE or DONE (busy=0). Start in RUN is ignored, and a/b/is_signed in that cycle have no effect.
- On accept, the block latches the operands:
  - Multiplier b is extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise. An implicit 0 is appended below the LSB.
  - Multiplicand a is extended to WIDTH+3 bits in the same manner. The block stores +M and 2M (shift); negation is applied at use.
  - Accumulator (2*WIDTH+4 bits) is cleared.
  - Step counter is cleared.
  - Next state is RUN.
- RUN, one step per cycle, for step k = 0..ITER-1:
  - Examine triplet {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0.
  - Digit mapping: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - Add the digit to the upper accumulator bits, then arithmetic-shift right by 2. Alternatively, use the equivalent shifted-add formulation; the result must match bit-exactly.
  - After step ITER-1, next state is DONE.
- DONE (one cycle):
  - product = low 2*WIDTH bits of the exact product.
  - done=1.
  - Next state is IDLE, or RUN if start is asserted.
- Arithmetic rules:
  - Results are exact for all operand pairs in both modes; there is no overflow.
  - Signed corner: −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2*WIDTH−2), which is representable.
  - Unsigned corner: (2^WIDTH−1)^2 is correct because of the extra recoding step.
- product is written only on entry to DONE. Intermediate accumulator values never appear on product.

## Timing
- Reset (synchronous, any state including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Accumulator and counter are cleared.
  - Any in-flight operation is discarded, with no done pulse.
- Reset has priority over start in the same cycle.
- Start accepted at edge E0:
  - busy=1 from after E0 through the edge that ends step ITER-1.
  - done=1 for exactly the cycle after edge E0+ITER, i.e. latency ITER+1 edges (WIDTH=8: 6).
  - busy and done are never high together.
- Back-to-back:
  - Start asserted during the done cycle is accepted.
  - The next done follows ITER+1 edges later.
  - Sustained throughput is one result per ITER+1 cycles.
- product is stable from the done cycle until the done cycle of the next operation.

## Test plan
- WIDTH=8, signed, a=−7 (0xF9), b=5 → done 6 edges after start; product=0xFFDD (−35); busy high for exactly 5 cycles.
- WIDTH=8 corners:
  - signed −128×−128 → 0x4000
  - signed −128×127 → 0xC080
  - unsigned 255×255 → 0xFE01
  - unsigned 0×200 → 0x0000
- WIDTH=8: start pulsed again at cycle 2 of RUN with different operands → ignored; product equals the first operation's result; a single done pulse.
- WIDTH=8: reset asserted in step 3 of RUN → next cycle busy=0, done=0, product=0, and no done pulse follows. A new start then completes normally.
- Back-to-back: start held high continuously with operand sets (3,4), (−2,−2) signed → done pulses 6 cycles apart with product 12 then 4.
- WIDTH=16 and WIDTH=4: 1000 random operand pairs with random is_signed against a reference model → all products match; latency is 10 and 4 edges respectively.
